// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// mag() works on a wide sign-extended value so one function serves any WIDTH < MAG_W.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MAG_W = 128;

  // Caller sign-extends (signed mode) or zero-extends (unsigned) before calling.
  function automatic logic [MAG_W-1:0] mag(input logic [MAG_W-1:0] val, input logic is_signed);
    logic [MAG_W-1:0] res;
    if (is_signed && val[MAG_W-1]) begin
      res = ~val + 128'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Accumulator / multiplier shift register / iteration counter for the shift-add multiplier.
// o_product_next exposes the accumulator value after the current step so the last step can be captured.
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  output logic                 o_last,
  output logic [2*WIDTH-1:0]   o_product_next
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH:0]  r_acc;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [CNT_W-1:0]  r_cnt;

  logic [WIDTH:0]    w_upper;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_upper_sel;
  logic [2*WIDTH:0]  w_acc_next;

  // Conditional add into the upper half, then shift the whole accumulator right.
  always_comb begin
    w_upper     = r_acc[2*WIDTH:WIDTH];
    w_sum       = w_upper + {1'b0, r_mcand};
    if (r_mplier[0]) begin
      w_upper_sel = w_sum;
    end else begin
      w_upper_sel = w_upper;
    end
    w_acc_next  = {w_upper_sel, r_acc[WIDTH-1:0]} >> 1;
  end

  // Datapath registers: cleared on reset and load, advanced on each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_cnt    <= CNT_W'(WIDTH - 1);
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last         = (r_cnt == '0);
  assign o_product_next = w_acc_next[2*WIDTH-1:0];

endmodule

// File: rtl/seq_mult.sv
// Iterative signed/unsigned multiplier: magnitudes are multiplied unsigned over WIDTH
// cycles and the sign is reapplied when the result is registered.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     input0,
  input  logic [WIDTH-1:0]     input1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   output0
);

  localparam int PAD = MAG_W - WIDTH;

  mult_state_t         r_state;
  mult_state_t         w_state_next;
  logic                r_neg;
  logic [2*WIDTH-1:0]  r_output0;

  logic                w_load;
  logic                w_step;
  logic                w_done_wr;
  logic                w_last;
  logic [MAG_W-1:0]    w_a_ext;
  logic [MAG_W-1:0]    w_b_ext;
  logic [WIDTH-1:0]    w_a_mag;
  logic [WIDTH-1:0]    w_b_mag;
  logic [2*WIDTH-1:0]  w_prod_next;
  logic [2*WIDTH-1:0]  w_prod_signed;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits.
  always_comb begin
    w_a_ext = {{PAD{is_signed & input0[WIDTH-1]}}, input0};
    w_b_ext = {{PAD{is_signed & input1[WIDTH-1]}}, input1};
    w_a_mag = WIDTH'(mag(w_a_ext, is_signed));
    w_b_mag = WIDTH'(mag(w_b_ext, is_signed));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control; DONE never accepts, so no bypass from DONE to CALC.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_done_wr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_state_next = CALC;
        end else begin
          w_state_next = IDLE;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (w_last) begin
          w_done_wr    = 1'b1;
          w_state_next = DONE;
        end else begin
          w_state_next = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  seq_mult_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk            (clk),
    .rst            (rst),
    .i_load         (w_load),
    .i_step         (w_step),
    .i_mcand        (w_a_mag),
    .i_mplier       (w_b_mag),
    .o_last         (w_last),
    .o_product_next (w_prod_next)
  );

  // Two's-complement negate wraps at 2*WIDTH bits.
  always_comb begin
    if (r_neg) begin
      w_prod_signed = ~w_prod_next + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_prod_signed = w_prod_next;
    end
  end

  // Result sign captured at accept; product register written only on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg     <= 1'b0;
      r_output0 <= '0;
    end else begin
      if (w_load) begin
        r_neg <= is_signed & (input0[WIDTH-1] ^ input1[WIDTH-1]);
      end
      if (w_done_wr) begin
        r_output0 <= w_prod_signed;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign output0   = r_output0;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at WIDTH=24 (directed, backpressure, reset, streaming)
// and WIDTH=4 (exhaustive); drivers push expectations, negedge monitors pop and compare.
module tb_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv24, ir24, s24, ov24, or24;
  logic [23:0] a24, b24;
  logic [47:0] p24;
  logic        iv4, ir4, s4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  seq_mult #(.WIDTH(24)) u_dut24 (
    .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(ir24), .is_signed(s24),
    .input0(a24), .input1(b24), .out_valid(ov24), .out_ready(or24), .output0(p24)
  );

  seq_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .is_signed(s4),
    .input0(a4), .input1(b4), .out_valid(ov4), .out_ready(or4), .output0(p4)
  );

  typedef struct {
    logic [63:0] exp;
    int          acc;
  } item_t;

  item_t q24[$];
  item_t q4[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;
  logic  hold24 = 1'b0;
  logic  hold4 = 1'b0;
  logic  spacing_chk = 1'b0;
  int    last_acc24 = -1;
  logic  pv24 = 1'b0;
  logic  pv4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    n_total++;
    $display("FAIL %s: got an event, required none", name);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w);
    longint sa, sb, pr;
    logic [63:0] mask;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    pr = sa * sb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(pr) & mask;
  endfunction

  // Monitor for the 24-bit instance: latency on out_valid rise, value on handshake.
  always @(negedge clk) begin
    item_t it;
    if (rst) begin
      pv24 = 1'b0;
    end else begin
      if (ov24 && !pv24) begin
        if (q24.size() == 0) note_fail("unexpected_valid24");
        else check("latency24", 64'(cyc - q24[0].acc), 64'd24);
      end
      if (ov24 && or24) begin
        if (q24.size() == 0) note_fail("unexpected_product24");
        else begin
          it = q24.pop_front();
          check("product24", {16'd0, p24}, it.exp);
        end
      end
      pv24 = ov24;
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    item_t it;
    if (rst) begin
      pv4 = 1'b0;
    end else begin
      if (ov4 && !pv4) begin
        if (q4.size() == 0) note_fail("unexpected_valid4");
        else check("latency4", 64'(cyc - q4[0].acc), 64'd4);
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) note_fail("unexpected_product4");
        else begin
          it = q4.pop_front();
          check("product4", {56'd0, p4}, it.exp);
        end
      end
      pv4 = ov4;
    end
  end

  // Called just after a posedge; returns just after the accept edge.
  task automatic issue24(input logic [23:0] a, input logic [23:0] b, input logic s,
                         input logic [63:0] exp);
    int budget;
    item_t it;
    a24 = a; b24 = b; s24 = s; iv24 = 1'b1;
    budget = 100;
    @(negedge clk);
    while (!ir24 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!ir24) begin
      note_fail("accept_timeout24");
    end else begin
      it.exp = exp;
      it.acc = cyc + 1;
      q24.push_back(it);
      if (spacing_chk && last_acc24 >= 0) check("spacing24", 64'(it.acc - last_acc24), 64'd26);
      last_acc24 = it.acc;
    end
    @(posedge clk);
    #2;
    if (!hold24) iv24 = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [63:0] exp);
    int budget;
    item_t it;
    a4 = a; b4 = b; s4 = s; iv4 = 1'b1;
    budget = 50;
    @(negedge clk);
    while (!ir4 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!ir4) begin
      note_fail("accept_timeout4");
    end else begin
      it.exp = exp;
      it.acc = cyc + 1;
      q4.push_back(it);
    end
    @(posedge clk);
    #2;
    if (!hold4) iv4 = 1'b0;
  endtask

  task automatic drain24();
    int budget = 200;
    while (q24.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q24.size() != 0) note_fail("drain_timeout24");
    @(posedge clk);
    #2;
  endtask

  task automatic drain4();
    int budget = 100;
    while (q4.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q4.size() != 0) note_fail("drain_timeout4");
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] sa, sb;
    logic [63:0] e;
    int budget;
    rst = 1'b1;
    iv24 = 1'b0; s24 = 1'b0; a24 = 24'd0; b24 = 24'd0; or24 = 1'b1;
    iv4 = 1'b0; s4 = 1'b0; a4 = 4'd0; b4 = 4'd0; or4 = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready24", {63'd0, ir24}, 64'd1);
    check("reset_out_valid24", {63'd0, ov24}, 64'd0);
    check("reset_output24", {16'd0, p24}, 64'd0);
    check("reset_in_ready4", {63'd0, ir4}, 64'd1);
    check("reset_out_valid4", {63'd0, ov4}, 64'd0);
    @(posedge clk);
    #2;

    // Directed vectors with hand-computed products.
    issue24(24'hFFFFFF, 24'hFFFFFF, 1'b0, 64'h0000_FFFF_FE00_0001); drain24();
    issue24(24'hFFFFFF, 24'hFFFFFF, 1'b1, 64'h0000_0000_0000_0001); drain24();
    issue24(24'h800000, 24'h800000, 1'b1, 64'h0000_4000_0000_0000); drain24();
    issue24(24'h800000, 24'h000001, 1'b1, 64'h0000_FFFF_FF80_0000); drain24();
    issue24(24'h000000, 24'h123456, 1'b0, 64'h0000_0000_0000_0000); drain24();
    issue24(24'h000000, 24'h123456, 1'b1, 64'h0000_0000_0000_0000); drain24();

    // Backpressure: 0x123 * 0x456 = 0x4EDC2 held while out_ready is low.
    or24 = 1'b0;
    issue24(24'h000123, 24'h000456, 1'b0, 64'h0000_0000_0004_EDC2);
    budget = 60;
    while (!ov24 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!ov24) note_fail("bp_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {63'd0, ov24}, 64'd1);
      check("bp_output", {16'd0, p24}, 64'h4EDC2);
      check("bp_in_ready", {63'd0, ir24}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #2 or24 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_released_valid", {63'd0, ov24}, 64'd0);
    check("bp_released_ready", {63'd0, ir24}, 64'd1);
    check("bp_queue_empty", 64'(q24.size()), 64'd0);
    @(posedge clk);
    #2;

    // Reset ten cycles after accept discards the operation.
    issue24(24'h000007, 24'h000009, 1'b0, 64'd63);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    q24.delete();
    @(negedge clk);
    check("rst_mid_out_valid", {63'd0, ov24}, 64'd0);
    check("rst_mid_in_ready", {63'd0, ir24}, 64'd1);
    @(posedge clk);
    #2;
    issue24(24'd3, 24'd5, 1'b0, 64'd15); drain24();

    // Streaming sweep with in_valid and out_ready held high.
    hold24 = 1'b1;
    spacing_chk = 1'b1;
    last_acc24 = -1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        sa = 24'hFED123 + 24'(m * 4 + i);
        sb = 24'hFBC456 + 24'(m * 4 + i);
        e = ref_mul({8'd0, sa}, {8'd0, sb}, m[0], 24);
        issue24(sa, sb, m[0], e);
      end
    end
    hold24 = 1'b0;
    iv24 = 1'b0;
    spacing_chk = 1'b0;
    drain24();

    // WIDTH=4 exhaustive in both modes.
    hold4 = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          e = ref_mul(32'(a), 32'(b), m[0], 4);
          issue4(4'(a), 4'(b), m[0], e);
        end
      end
    end
    hold4 = 1'b0;
    iv4 = 1'b0;
    drain4();

    check("final_queue24_empty", 64'(q24.size()), 64'd0);
    check("final_queue4_empty", 64'(q4.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
